// File: rtl/perm_gen.sv
// perm_gen: steps through the permutations of 0..N-1 in lexicographic order,
// one request at a time, using a pivot / swap / suffix-reverse sequence.
// Optional feature: define PERM_GEN_COUNT_EN to add the 16-bit perm_cnt output
// (permutations produced since start, cleared on wrap, saturating).
module perm_gen #(
    parameter int N    = 8,
    parameter int WRAP = 0,
    localparam int W   = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    input  logic           next_req,
    output logic [N*W-1:0] perm,
    output logic           valid,
    output logic           busy,
    output logic           last
`ifdef PERM_GEN_COUNT_EN
   ,output logic [15:0]    perm_cnt
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READY   = 3'd1;
    localparam logic [2:0] PIVOT   = 3'd2;
    localparam logic [2:0] SWAP    = 3'd3;
    localparam logic [2:0] REVERSE = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] perm_q [N];
    logic [W-1:0] perm_d [N];
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] s_q, s_d;

    logic         has_piv;
    logic [W-1:0] piv;
    logic [W-1:0] succ;
    logic         rev_done;

    // Pivot search: rightmost ascent; no ascent means the sequence is fully descending
    always_comb begin
        has_piv = 1'b0;
        piv     = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[i] < perm_q[i + 1]) begin
                has_piv = 1'b1;
                piv     = W'(i);
            end
        end
    end

    // Successor search: rightmost element past the pivot that is larger than it
    always_comb begin
        succ = '0;
        for (int j = 0; j < N; j++) begin
            if ((j > int'(piv)) && (perm_q[j] > perm_q[piv])) begin
                succ = W'(j);
            end
        end
    end

    // The reverse phase finishes once this cycle's swap (if any) closes the window
    assign rev_done = (state_q == REVERSE) && ((int'(lo_q) + 2) >= int'(hi_q));

    // Next-state and datapath update; start overrides everything else
    always_comb begin
        state_d = state_q;
        perm_d  = perm_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        p_d     = p_q;
        s_d     = s_q;
        case (state_q)
            READY: begin
                if (next_req && (has_piv || (WRAP != 0))) begin
                    state_d = PIVOT;
                end
            end
            PIVOT: begin
                if (has_piv) begin
                    p_d     = piv;
                    s_d     = succ;
                    state_d = SWAP;
                end else begin
                    lo_d    = '0;
                    hi_d    = W'(N - 1);
                    state_d = REVERSE;
                end
            end
            SWAP: begin
                perm_d[p_q] = perm_q[s_q];
                perm_d[s_q] = perm_q[p_q];
                lo_d        = p_q + W'(1);
                hi_d        = W'(N - 1);
                state_d     = REVERSE;
            end
            REVERSE: begin
                if (lo_q < hi_q) begin
                    perm_d[lo_q] = perm_q[hi_q];
                    perm_d[hi_q] = perm_q[lo_q];
                    lo_d         = lo_q + W'(1);
                    hi_d         = hi_q - W'(1);
                end
                if (rev_done) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (start) begin
            state_d = READY;
            lo_d    = '0;
            hi_d    = '0;
            for (int i = 0; i < N; i++) begin
                perm_d[i] = W'(i);
            end
        end
    end

    // State and permutation registers; reset drops any half-finished step
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            p_q     <= '0;
            s_q     <= '0;
            for (int i = 0; i < N; i++) begin
                perm_q[i] <= W'(i);
            end
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            p_q     <= p_d;
            s_q     <= s_d;
            for (int i = 0; i < N; i++) begin
                perm_q[i] <= perm_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign perm[g*W +: W] = perm_q[g];
    end

    assign valid = (state_q == READY);
    assign busy  = (state_q == PIVOT) || (state_q == SWAP) || (state_q == REVERSE);
    assign last  = ~has_piv;

`ifdef PERM_GEN_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        wrap_q, wrap_d;

    // Count completed steps; a wrap step leaves the count at zero
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        if (start) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
        end else if (state_q == PIVOT) begin
            wrap_d = ~has_piv;
            if (!has_piv) begin
                cnt_d = '0;
            end
        end else if (rev_done) begin
            wrap_d = 1'b0;
            if (!wrap_q && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign perm_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_perm_gen.sv
// Bench for perm_gen: three instances (N=4 no wrap, N=4 wrap, N=8 no wrap)
// checked every cycle against a rank/unrank permutation model, plus literals.
`timescale 1ns/1ps
module tb_perm_gen;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        st [3];
    logic        nx [3];
    logic [7:0]  p0, p1;
    logic [23:0] p2;
    logic        v [3];
    logic        b [3];
    logic        l [3];
    logic [23:0] dperm [3];
`ifdef PERM_GEN_COUNT_EN
    logic [15:0] c0, c1, c2;
    logic [15:0] dcnt [3];
    assign dcnt[0] = c0;
    assign dcnt[1] = c1;
    assign dcnt[2] = c2;
`endif

    assign dperm[0] = {16'b0, p0};
    assign dperm[1] = {16'b0, p1};
    assign dperm[2] = p2;

    perm_gen #(.N(4), .WRAP(0)) u4 (
        .CLK(CLK), .RST_N(RST_N), .start(st[0]), .next_req(nx[0]),
        .perm(p0), .valid(v[0]), .busy(b[0]), .last(l[0])
`ifdef PERM_GEN_COUNT_EN
       ,.perm_cnt(c0)
`endif
    );

    perm_gen #(.N(4), .WRAP(1)) u4w (
        .CLK(CLK), .RST_N(RST_N), .start(st[1]), .next_req(nx[1]),
        .perm(p1), .valid(v[1]), .busy(b[1]), .last(l[1])
`ifdef PERM_GEN_COUNT_EN
       ,.perm_cnt(c1)
`endif
    );

    perm_gen #(.N(8), .WRAP(0)) u8 (
        .CLK(CLK), .RST_N(RST_N), .start(st[2]), .next_req(nx[2]),
        .perm(p2), .valid(v[2]), .busy(b[2]), .last(l[2])
`ifdef PERM_GEN_COUNT_EN
       ,.perm_cnt(c2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // model: 0 = idle, 1 = ready, 2 = stepping
    int mstate [3];
    int mperm [3][8];
    int mtgt [3][8];
    int mleft [3];
    int mcnt [3];
    int mtcnt [3];

    function automatic int nn(input int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic bit wr(input int k);
        return (k == 1);
    endfunction

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    // Lexicographic rank of a permutation (Lehmer code)
    function automatic int rank_of(input int a[8], input int n);
        int r = 0;
        for (int i = 0; i < n; i++) begin
            int c = 0;
            for (int j = i + 1; j < n; j++) if (a[j] < a[i]) c++;
            r = r + c * fact(n - 1 - i);
        end
        return r;
    endfunction

    function automatic void unrank(input int r, input int n, output int a[8]);
        bit used[8];
        int rr = r;
        for (int i = 0; i < 8; i++) begin used[i] = 0; a[i] = 0; end
        for (int i = 0; i < n; i++) begin
            int f = fact(n - 1 - i);
            int d = rr / f;
            rr = rr % f;
            for (int e = 0; e < n; e++) begin
                if (!used[e]) begin
                    if (d == 0) begin a[i] = e; used[e] = 1; break; end
                    d--;
                end
            end
        end
    endfunction

    function automatic logic [23:0] pack(input int a[8], input int n);
        logic [23:0] x = '0;
        int w = (n == 8) ? 3 : 2;
        for (int i = 0; i < n; i++) x = x | (24'(a[i]) << (i * w));
        return x;
    endfunction

    function automatic bit is_perm(input logic [23:0] x, input int n);
        bit seen[8];
        int w = (n == 8) ? 3 : 2;
        for (int i = 0; i < 8; i++) seen[i] = 0;
        for (int i = 0; i < n; i++) begin
            int e = int'((x >> (i * w)) & ((24'd1 << w) - 24'd1));
            if (e >= n || seen[e]) return 0;
            seen[e] = 1;
        end
        return 1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model advance for the edge just passed, then check every instance
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            int n, r, f, p;
            int tmp[8];
            n = nn(k);
            if (!RST_N || st[k]) begin
                mstate[k] = RST_N ? 1 : 0;
                mcnt[k] = 0;
                for (int i = 0; i < 8; i++) mperm[k][i] = i;
            end else if (mstate[k] == 1) begin
                if (nx[k]) begin
                    r = rank_of(mperm[k], n);
                    f = fact(n);
                    if (!(r == f - 1 && !wr(k))) begin
                        unrank((r + 1) % f, n, tmp);
                        for (int i = 0; i < 8; i++) mtgt[k][i] = tmp[i];
                        if (r == f - 1) begin
                            mleft[k] = 1 + n / 2;
                            mtcnt[k] = 0;
                        end else begin
                            p = 0;
                            while (p < n && tmp[p] == mperm[k][p]) p++;
                            mleft[k] = 2 + (((n - 1 - p) / 2 > 1) ? (n - 1 - p) / 2 : 1);
                            mtcnt[k] = (mcnt[k] < 65535) ? mcnt[k] + 1 : 65535;
                        end
                        mstate[k] = 2;
                    end
                end
            end else if (mstate[k] == 2) begin
                mleft[k]--;
                if (mleft[k] == 0) begin
                    for (int i = 0; i < 8; i++) mperm[k][i] = mtgt[k][i];
                    mcnt[k] = mtcnt[k];
                    mstate[k] = 1;
                end
            end

            if (mstate[k] == 0) begin
                chk("idle_valid_busy", k, {30'b0, v[k], b[k]}, 32'd0);
                chk("idle_perm", k, {8'b0, dperm[k]}, {8'b0, pack(mperm[k], n)});
            end else if (mstate[k] == 1) begin
                chk("ready_valid_busy", k, {30'b0, v[k], b[k]}, 32'd2);
                chk("ready_perm", k, {8'b0, dperm[k]}, {8'b0, pack(mperm[k], n)});
                chk("ready_last", k, {31'b0, l[k]},
                    {31'b0, (rank_of(mperm[k], n) == fact(n) - 1)});
`ifdef PERM_GEN_COUNT_EN
                chk("ready_cnt", k, {16'b0, dcnt[k]}, 32'(mcnt[k]));
`endif
            end else begin
                chk("step_valid_busy", k, {30'b0, v[k], b[k]}, 32'd1);
                chk("step_is_perm", k, {31'b0, is_perm(dperm[k], n)}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic step(input int k);
        int t = 0;
        nx[k] = 1'b1;
        tick();
        nx[k] = 1'b0;
        while (!v[k] && t < 40) begin tick(); t++; end
        if (t >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL step_timeout[%0d]: valid still %0b after %0d cycles", k, v[k], t);
        end
    endtask

    task automatic count_busy(input int k, output int nb);
        nb = 0;
        nx[k] = 1'b1;
        tick();
        nx[k] = 1'b0;
        while (b[k] && nb < 20) begin nb++; tick(); end
    endtask

    initial begin
        int nb;
        RST_N = 1'b0;
        for (int k = 0; k < 3; k++) begin st[k] = 1'b0; nx[k] = 1'b0; end
        repeat (3) tick();
        chk("rst_valid", 0, {31'b0, v[0]}, 32'd0);
        chk("rst_perm", 2, {8'b0, p2}, 32'hFAC688);
        RST_N = 1'b1;
        tick();
        chk("idle_busy", 0, {31'b0, b[0]}, 32'd0);

        // start all; identity ready the next cycle
        for (int k = 0; k < 3; k++) st[k] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) st[k] = 1'b0;
        chk("start_valid", 0, {31'b0, v[0]}, 32'd1);
        chk("start_perm", 0, {24'b0, p0}, 32'hE4);
        chk("start_last", 0, {31'b0, l[0]}, 32'd0);

        // first step: 0,1,2,3 -> 0,1,3,2 in three busy cycles
        count_busy(0, nb);
        chk("first_busy_cycles", 0, 32'(nb), 32'd3);
        chk("first_perm", 0, {24'b0, p0}, 32'hB4);

        // walk to the final permutation and try to go past it
        repeat (22) step(0);
        chk("final_perm", 0, {24'b0, p0}, 32'h1B);
        chk("final_last", 0, {31'b0, l[0]}, 32'd1);
`ifdef PERM_GEN_COUNT_EN
        chk("final_cnt", 0, {16'b0, c0}, 32'd23);
`endif
        nx[0] = 1'b1;
        tick();
        nx[0] = 1'b0;
        chk("nowrap_busy", 0, {31'b0, b[0]}, 32'd0);
        tick();
        chk("nowrap_perm", 0, {24'b0, p0}, 32'h1B);

        // wrapping instance returns to identity from 3,2,1,0
        repeat (23) step(1);
        chk("wrap_pre_perm", 1, {24'b0, p1}, 32'h1B);
        count_busy(1, nb);
        chk("wrap_busy_cycles", 1, 32'(nb), 32'd3);
        chk("wrap_perm", 1, {24'b0, p1}, 32'hE4);
`ifdef PERM_GEN_COUNT_EN
        chk("wrap_cnt", 1, {16'b0, c1}, 32'd0);
`endif

        // N=8: start while reversing
        repeat (5) step(2);
        nx[2] = 1'b1;
        tick();
        nx[2] = 1'b0;
        tick();
        chk("swap_busy", 2, {31'b0, b[2]}, 32'd1);
        tick();
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        chk("abort_valid", 2, {31'b0, v[2]}, 32'd1);
        chk("abort_perm", 2, {8'b0, p2}, 32'hFAC688);

        // N=8: reset while swapping
        repeat (5) step(2);
        nx[2] = 1'b1;
        tick();
        nx[2] = 1'b0;
        tick();
        #1 RST_N = 1'b0;
        #1;
        chk("rst_mid_valid", 2, {31'b0, v[2]}, 32'd0);
        chk("rst_mid_busy", 2, {31'b0, b[2]}, 32'd0);
        chk("rst_mid_perm", 2, {8'b0, p2}, 32'hFAC688);
        tick();
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) st[k] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) st[k] = 1'b0;

        // random traffic against the model
        for (int c = 0; c < 6000; c++) begin
            RST_N = 1'b1;
            for (int k = 0; k < 3; k++) begin
                st[k] = ($urandom_range(0, 199) == 0) ||
                        (mstate[k] == 0 && $urandom_range(0, 3) == 0);
                nx[k] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2999) == 0) RST_N = 1'b0;
            tick();
        end
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin st[k] = 1'b0; nx[k] = 1'b0; end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perm_gen.md
PERM_GEN -- requirements
Module: perm_gen

Interface
REQ-001 SHALL have parameter N, default 8, meaning the element count, legal range 2..8.
REQ-002 SHALL have parameter WRAP, default 0; when 1, advancing past the final permutation returns to identity.
REQ-003 SHALL derive local W = clog2(N) as the element width.
REQ-004 SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: load identity and begin a sequence.
REQ-007 SHALL have port next_req, input, 1 bit: request the next lexicographic permutation.
REQ-008 SHALL have port perm, output, N*W bits: element i at bits [i*W +: W].
REQ-009 SHALL have port valid, output, 1 bit: perm is stable and next_req can be accepted.
REQ-010 SHALL have port busy, output, 1 bit: a permutation step is in progress.
REQ-011 SHALL have port last, output, 1 bit: perm is strictly descending (final permutation).

Function
REQ-012 SHALL use states IDLE, READY, PIVOT, SWAP, REVERSE.
REQ-013 IDLE: valid=0, busy=0; start moves to READY and loads perm[i]=i on the same edge.
REQ-014 READY: valid=1, busy=0; next_req moves to PIVOT, except when last=1 and WRAP=0, where next_req is ignored and the state stays READY.
REQ-015 PIVOT (1 cycle): p = largest i with perm[i] < perm[i+1]; s = largest j > p with perm[j] > perm[p]; go to SWAP.
REQ-016 PIVOT with no pivot (WRAP=1 only): set lo=0, hi=N-1 and go directly to REVERSE.
REQ-017 SWAP (1 cycle): exchange perm[p] and perm[s]; set lo=p+1, hi=N-1; go to REVERSE.
REQ-018 REVERSE: each cycle with lo<hi, exchange perm[lo] and perm[hi], then lo+1 and hi-1; when lo>=hi, return to READY without a swap.
REQ-019 REVERSE SHALL occupy max(1, floor((hi-lo+1)/2)) cycles.
REQ-020 Latency from next_req accepted to valid=1 SHALL be 2 + max(1, floor((N-1-p)/2)) cycles, or 1 + floor(N/2) for wrap.
REQ-021 busy SHALL be 1 exactly in PIVOT, SWAP and REVERSE; valid and busy SHALL never both be 1.
REQ-022 last SHALL be combinational from perm and is meaningful only while valid=1.
REQ-023 start in any state SHALL abort any step, load identity and enter READY next cycle; start has priority over a simultaneous next_req.
REQ-024 next_req outside READY SHALL be ignored and not queued.
REQ-025 perm SHALL always be a permutation of 0..N-1, including mid-step.

Reset
REQ-026 RST_N low SHALL immediately force state IDLE, perm[i]=i, valid=0, busy=0, lo=0, hi=0, and perm_cnt=0 when present.
REQ-027 Reset assertion mid-step SHALL abandon the step with no partial swap retained.

Configuration
REQ-028 With PERM_GEN_COUNT_EN defined, the block SHALL add output perm_cnt (16 bits): cleared on start, +1 on each return to READY from REVERSE, set to 0 on wrap, saturating at 16'hFFFF.
REQ-029 Without PERM_GEN_COUNT_EN, there SHALL be no perm_cnt port and no counter logic.

Verification
REQ-030 N=4, reset then start -> next cycle valid=1, perm=0,1,2,3, last=0.
REQ-031 N=4 from 0,1,2,3, pulse next_req -> busy for 3 cycles, then valid with perm=0,1,3,2.
REQ-032 N=4, 23 accepted next_req -> perm=3,2,1,0, last=1, perm_cnt=23; a further next_req with WRAP=0 -> no change, busy stays 0.
REQ-033 N=4, WRAP=1 at 3,2,1,0, next_req -> busy 3 cycles, perm=0,1,2,3, perm_cnt=0.
REQ-034 N=8, start asserted during REVERSE -> next cycle identity, valid=1; RST_N low mid-SWAP -> immediate identity, valid=0.
REQ-035 N=8, walk all permutations -> 40320 distinct values in strict lexicographic order, last=1 only at 7..0.
